// File: rtl/amux_seq_pkg.sv
// Shared types and constants for the AMUXBUS break-before-make switch sequencer.
package amux_seq_pkg;

  localparam int unsigned CNT_W = $clog2(256);

  localparam logic OP_DISC = 1'b0;
  localparam logic OP_CONN = 1'b1;
  localparam logic BUS_A   = 1'b0;
  localparam logic BUS_B   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Operation and bus of the request currently in flight
  typedef struct packed {
    logic conn;
    logic bus;
  } req_ctl_t;

  // Counter load value for an interval of cyc cycles
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/amux_switch_seq_if.sv
// Request handshake and switch-enable bundle between core control and the sequencer.
interface amux_switch_seq_if #(
  parameter int unsigned N_SRC = 8
);
  localparam int unsigned SRC_W = $clog2(N_SRC);

  logic             req_valid;
  logic             req_ready;
  logic             req_conn;
  logic             req_bus;
  logic [SRC_W-1:0] req_src;
  logic             kill;
  logic [N_SRC-1:0] sel_a_en;
  logic [N_SRC-1:0] sel_b_en;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output req_valid, req_conn, req_bus, req_src, kill,
    input  req_ready, sel_a_en, sel_b_en, done, err, busy
  );

  modport slave (
    input  req_valid, req_conn, req_bus, req_src, kill,
    output req_ready, sel_a_en, sel_b_en, done, err, busy
  );

endinterface

// File: rtl/amux_delay_cnt.sv
// Loadable saturating down-counter timing the BREAK and MAKE settle intervals.
module amux_delay_cnt
  import amux_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Stops at zero so an idle counter never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/amux_switch_seq.sv
// Break-before-make sequencer owning the AMUXBUS_A/B switch enables of the pad ring.
// Each bus holds at most one source and no source ever sits on both buses.
module amux_switch_seq
  import amux_seq_pkg::*;
#(
  parameter int unsigned N_SRC     = 8,
  parameter int unsigned BREAK_CYC = 4,
  parameter int unsigned MAKE_CYC  = 4
) (
  input  logic               clock,
  input  logic               resetn,
  amux_switch_seq_if.slave   bus_if
);

  localparam logic [CNT_W-1:0] BREAK_LD = cyc_load(BREAK_CYC);
  localparam logic [CNT_W-1:0] MAKE_LD  = cyc_load(MAKE_CYC);

  state_e           state_q, state_d;
  logic [N_SRC-1:0] sel_a_q, sel_a_d;
  logic [N_SRC-1:0] sel_b_q, sel_b_d;
  logic [N_SRC-1:0] tgt_q, tgt_d;
  req_ctl_t         ctl_q, ctl_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  logic             accept;
  logic             src_ok;
  logic [N_SRC-1:0] req_tgt;
  logic [N_SRC-1:0] cur_x, cur_o;
  logic [N_SRC-1:0] open_x, open_o;
  logic [N_SRC-1:0] open_a, open_b;

  assign bus_if.req_ready = (state_q == ST_IDLE) && !bus_if.kill;
  assign accept           = bus_if.req_valid && bus_if.req_ready;

  // Open-set of the incoming request: what must drop before anything closes
  assign src_ok  = (32'(bus_if.req_src) < N_SRC);
  assign req_tgt = src_ok ? (N_SRC'(1) << bus_if.req_src) : '0;
  assign cur_x   = (bus_if.req_bus == BUS_B) ? sel_b_q : sel_a_q;
  assign cur_o   = (bus_if.req_bus == BUS_B) ? sel_a_q : sel_b_q;
  assign open_x  = (bus_if.req_conn == OP_DISC) ? (cur_x & req_tgt) : (cur_x & ~req_tgt);
  assign open_o  = (bus_if.req_conn == OP_CONN) ? (cur_o & req_tgt) : '0;
  assign open_a  = (bus_if.req_bus == BUS_B) ? open_o : open_x;
  assign open_b  = (bus_if.req_bus == BUS_B) ? open_x : open_o;

  amux_delay_cnt u_cnt (
    .clk     (clock),
    .rst_n   (resetn),
    .load_i  (cnt_load),
    .clr_i   (bus_if.kill),
    .value_i (cnt_val),
    .zero_o  (cnt_zero)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      sel_a_q <= '0;
      sel_b_q <= '0;
      tgt_q   <= '0;
      ctl_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      tgt_q   <= tgt_d;
      ctl_q   <= ctl_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_a_d  = sel_a_q;
    sel_b_d  = sel_b_q;
    tgt_d    = tgt_q;
    ctl_d    = ctl_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ctl_d = '{conn: bus_if.req_conn, bus: bus_if.req_bus};
          tgt_d = req_tgt;
          if (!src_ok) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (|(open_a | open_b)) begin
            sel_a_d  = sel_a_q & ~open_a;
            sel_b_d  = sel_b_q & ~open_b;
            state_d  = ST_BREAK;
            cnt_load = 1'b1;
            cnt_val  = BREAK_LD;
          end else if ((bus_if.req_conn == OP_CONN) && !(|(cur_x & req_tgt))) begin
            if (bus_if.req_bus == BUS_A) sel_a_d = sel_a_q | req_tgt;
            else                         sel_b_d = sel_b_q | req_tgt;
            state_d  = ST_MAKE;
            cnt_load = 1'b1;
            cnt_val  = MAKE_LD;
          end else begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (cnt_zero) begin
          if (ctl_q.conn == OP_CONN) begin
            if (ctl_q.bus == BUS_A) sel_a_d = sel_a_q | tgt_q;
            else                    sel_b_d = sel_b_q | tgt_q;
            state_d  = ST_MAKE;
            cnt_load = 1'b1;
            cnt_val  = MAKE_LD;
          end else begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
      end
      ST_MAKE: begin
        if (cnt_zero) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Emergency open-all; only a request still settling reports the abort
    if (bus_if.kill) begin
      sel_a_d  = '0;
      sel_b_d  = '0;
      state_d  = ST_IDLE;
      cnt_load = 1'b0;
      done_d   = (state_q == ST_BREAK) || (state_q == ST_MAKE);
      err_d    = (state_q == ST_BREAK) || (state_q == ST_MAKE);
    end
  end

  assign bus_if.sel_a_en = sel_a_q;
  assign bus_if.sel_b_en = sel_b_q;
  assign bus_if.done     = done_q;
  assign bus_if.err      = err_q;
  assign bus_if.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_amux_switch_seq.sv
// Scoreboard bench for amux_switch_seq: a holder-per-bus reference model predicts each
// request's completion cycle, error flag and enables; a negedge monitor checks them.
module tb_amux_switch_seq;

  localparam int N  = 6;
  localparam int B  = 3;
  localparam int M  = 5;
  localparam int SW = $clog2(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  amux_switch_seq_if #(.N_SRC(N)) sif ();

  amux_switch_seq #(
    .N_SRC     (N),
    .BREAK_CYC (B),
    .MAKE_CYC  (M)
  ) dut (
    .clock  (clk),
    .resetn (rst_n),
    .bus_if (sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           lat;
    bit           err;
    bit           killed;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ha       = -1;
  int   hb       = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] msk(input int h);
    logic [N-1:0] m;
    m = '0;
    if (h >= 0) m[h] = 1'b1;
    return m;
  endfunction

  // Reference model: bus holders as source numbers (-1 = empty)
  task automatic model_push(input bit conn, input bit bus, input int src,
                            input int kill_at, output int kill_eff);
    exp_t e;
    int hx, ho, cx, co, nx, no;
    hx = bus ? hb : ha;
    ho = bus ? ha : hb;
    cx = hx; co = ho; nx = hx; no = ho;
    e.lat = 1; e.err = 1'b0; e.killed = 1'b0;
    if (src >= N) begin
      e.err = 1'b1;
    end else if (conn) begin
      if ((hx >= 0 && hx != src) || ho == src) begin
        cx = -1;
        co = (ho == src) ? -1 : ho;
        nx = src;
        no = co;
        e.lat = 1 + B + M;
      end else if (hx != src) begin
        cx = src;
        nx = src;
        e.lat = 1 + M;
      end
    end else if (hx == src) begin
      cx = -1;
      nx = -1;
      e.lat = 1 + B;
    end
    e.a1 = bus ? msk(co) : msk(cx);
    e.b1 = bus ? msk(cx) : msk(co);
    if (kill_at >= 2 && kill_at <= e.lat) begin
      e.lat = kill_at; e.err = 1'b1; e.killed = 1'b1;
      nx = -1; no = -1;
      kill_eff = kill_at;
    end else begin
      kill_eff = 0;
    end
    e.a = bus ? msk(no) : msk(nx);
    e.b = bus ? msk(nx) : msk(no);
    ha = bus ? no : nx;
    hb = bus ? nx : no;
    sb_q.push_back(e);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (sif.req_ready) return;
      @(posedge clk); #1;
    end
    chk("ready_timeout", 32'(sif.req_ready), 32'(1));
  endtask

  task automatic drive_req(input bit conn, input bit bus, input int src);
    sif.req_conn  = conn;
    sif.req_bus   = bus;
    sif.req_src   = SW'(src);
    sif.req_valid = 1'b1;
    @(posedge clk); #1;
    sif.req_valid = 1'b0;
    sif.req_conn  = 1'($urandom_range(0, 1));
    sif.req_bus   = 1'($urandom_range(0, 1));
    sif.req_src   = SW'($urandom_range(0, 7));
  endtask

  task automatic send(input bit conn, input bit bus, input int src, input int kill_at);
    int k;
    wait_ready();
    model_push(conn, bus, src, kill_at, k);
    drive_req(conn, bus, src);
    if (k > 0) begin
      repeat (k - 2) @(posedge clk);
      #1 sif.kill = 1'b1;
      @(posedge clk); #1 sif.kill = 1'b0;
    end
    wait_ready();
  endtask

  task automatic idle_kill();
    wait_ready();
    sif.kill = 1'b1;
    @(posedge clk); #1 sif.kill = 1'b0;
    ha = -1;
    hb = -1;
    chk("kill_idle_a", 32'(sif.sel_a_en), 32'(0));
    chk("kill_idle_b", 32'(sif.sel_b_en), 32'(0));
  endtask

  // Monitor: cycle 1 is the interval right after the acceptance edge
  int           acc_cyc = 0;
  bit           pend    = 1'b0;
  logic [N-1:0] pa      = '0;
  logic [N-1:0] pb      = '0;

  always @(negedge clk) begin
    exp_t e;
    int   rel;
    bit   eb;
    if (!rst_n) begin
      pend = 1'b0;
      sb_q.delete();
      pa = '0;
      pb = '0;
    end else begin
      rel = cyc - acc_cyc + 1;
      chk("onehot_a", 32'($countones(sif.sel_a_en) <= 1), 32'(1));
      chk("onehot_b", 32'($countones(sif.sel_b_en) <= 1), 32'(1));
      chk("disjoint", 32'(sif.sel_a_en & sif.sel_b_en), 32'(0));
      chk("rise_with_fall",
          32'((|((sif.sel_a_en & ~pa) | (sif.sel_b_en & ~pb))) &&
              (|((pa & ~sif.sel_a_en) | (pb & ~sif.sel_b_en)))), 32'(0));
      pa = sif.sel_a_en;
      pb = sif.sel_b_en;

      eb = pend && (rel >= 1) &&
           !(sb_q.size() > 0 && sb_q[0].killed && rel == sb_q[0].lat);
      chk("busy", 32'(sif.busy), 32'(eb));
      chk("req_ready", 32'(sif.req_ready), 32'(!eb && !sif.kill));

      if (pend && sb_q.size() > 0 && rel == 1) begin
        chk("cyc1_sel_a", 32'(sif.sel_a_en), 32'(sb_q[0].a1));
        chk("cyc1_sel_b", 32'(sif.sel_b_en), 32'(sb_q[0].b1));
      end

      if (sif.done) begin
        if (pend && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("done_cycle", 32'(rel), 32'(e.lat));
          chk("err", 32'(sif.err), 32'(e.err));
          chk("done_sel_a", 32'(sif.sel_a_en), 32'(e.a));
          chk("done_sel_b", 32'(sif.sel_b_en), 32'(e.b));
          pend = 1'b0;
        end else begin
          chk("spurious_done", 32'(sif.done), 32'(0));
        end
      end else begin
        chk("err_without_done", 32'(sif.err), 32'(0));
        if (pend && rel > 60) begin
          chk("done_timeout", 32'(sif.done), 32'(1));
          pend = 1'b0;
          if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
      end

      if (sif.req_valid && sif.req_ready) begin
        pend    = 1'b1;
        acc_cyc = cyc + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    sif.req_valid = 1'b0;
    sif.req_conn  = 1'b0;
    sif.req_bus   = 1'b0;
    sif.req_src   = '0;
    sif.kill      = 1'b0;

    #12;
    chk("rst_sel_a", 32'(sif.sel_a_en), 32'(0));
    chk("rst_sel_b", 32'(sif.sel_b_en), 32'(0));
    chk("rst_done", 32'(sif.done), 32'(0));
    chk("rst_err", 32'(sif.err), 32'(0));
    chk("rst_busy", 32'(sif.busy), 32'(0));
    chk("rst_ready", 32'(sif.req_ready), 32'(1));
    @(posedge clk); #1 rst_n = 1'b1;

    send(1'b1, 1'b0, 3, 0);   // empty bus connect
    send(1'b1, 1'b0, 5, 0);   // holder replacement
    send(1'b1, 1'b1, 5, 0);   // cross-bus move A->B
    send(1'b1, 1'b0, 5, 0);   // cross-bus move B->A
    send(1'b0, 1'b0, 5, 0);   // disconnect present
    send(1'b0, 1'b0, 5, 0);   // disconnect absent
    send(1'b1, 1'b1, 7, 0);   // invalid source
    send(1'b1, 1'b0, 2, 4);   // kill during MAKE
    send(1'b1, 1'b1, 1, 0);
    send(1'b1, 1'b1, 1, 0);   // already connected
    idle_kill();

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) idle_kill();
      send(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 10)) : 0);
    end

    // Asynchronous reset in the middle of a BREAK interval
    send(1'b1, 1'b0, 1, 0);
    wait_ready();
    model_push(1'b1, 1'b0, 4, 0, k);
    drive_req(1'b1, 1'b0, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sel_a", 32'(sif.sel_a_en), 32'(0));
    chk("midrst_sel_b", 32'(sif.sel_b_en), 32'(0));
    chk("midrst_done", 32'(sif.done), 32'(0));
    chk("midrst_busy", 32'(sif.busy), 32'(0));
    chk("midrst_ready", 32'(sif.req_ready), 32'(1));
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 32'(sif.done), 32'(0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    ha = -1;
    hb = -1;

    send(1'b1, 1'b1, 4, 0);
    repeat (3) @(posedge clk);
    #1 chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
